// File: rtl/shift_unit_if.sv
// shift_unit_if: request/result bundle for the multicycle shift unit.
// The master (control FSM / bench) drives the request; the slave (shift_unit)
// returns the working register and the Busy/Done handshake.
interface shift_unit_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
);
    logic               Start;
    logic [1:0]         Op;
    logic [SHAMT_W-1:0] ShiftAmt;
    logic [WIDTH-1:0]   DataIn;
    logic [WIDTH-1:0]   DataOut;
    logic               Busy;
    logic               Done;

    modport master (
        output Start, Op, ShiftAmt, DataIn,
        input  DataOut, Busy, Done
    );

    modport slave (
        input  Start, Op, ShiftAmt, DataIn,
        output DataOut, Busy, Done
    );
endinterface

// File: rtl/shift_unit.sv
// shift_unit: shifts a WIDTH-bit operand one bit per clock (SLL/SRL/SRA).
// Op=11 is pass-through by default; build with SHIFT_ROTATE_EN defined to make
// it a rotate right with the same latency as the other operations.
// Reset is synchronous and active-high.
module shift_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic        clk,
    input  logic        reset,
    shift_unit_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROT = 2'b11
    } op_e;

    state_e             state_q, state_d;
    op_e                op_q, op_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic               no_shift;

    // An operation with nothing to shift skips SHIFT and goes straight to DONE.
`ifdef SHIFT_ROTATE_EN
    assign no_shift = (bus.ShiftAmt == '0);
`else
    assign no_shift = (bus.ShiftAmt == '0) || (op_e'(bus.Op) == OP_ROT);
`endif

    // Next-state and datapath: latch the request in IDLE, one bit per SHIFT cycle.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d = state_q;
        op_d    = op_q;
        data_d  = data_q;
        cnt_d   = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (bus.Start) begin
                    data_d  = bus.DataIn;
                    op_d    = op_e'(bus.Op);
                    cnt_d   = bus.ShiftAmt;
                    state_d = no_shift ? S_DONE : S_SHIFT;
                end
            end

            S_SHIFT: begin
                case (op_q)
                    OP_SLL: data_d = {data_q[WIDTH-2:0], 1'b0};
                    OP_SRL: data_d = {1'b0, data_q[WIDTH-1:1]};
                    OP_SRA: data_d = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
`ifdef SHIFT_ROTATE_EN
                    OP_ROT: data_d = {data_q[0], data_q[WIDTH-1:1]};
`else
                    OP_ROT: data_d = data_q;
`endif
                    default: data_d = data_q;
                endcase
                cnt_d = cnt_q - SHAMT_W'(1);
                // Exit on count 1 so the counter lands on 0 and never wraps.
                if (cnt_q == SHAMT_W'(1)) begin
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                // Start is ignored here; the result holds into IDLE.
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset; reset aborts any operation.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so all registers update together on the edge.
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= OP_SLL;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.DataOut = data_q;
    assign bus.Busy    = (state_q == S_SHIFT);
    assign bus.Done    = (state_q == S_DONE);

endmodule

// File: tb/tb_shift_unit.sv
// tb_shift_unit: directed checks of the multicycle shift unit.
// Inputs change 1 ns after a rising edge; outputs are sampled on the falling edge.
// Edge k counts rising edges after Start is raised; edge 1 accepts the request.
module tb_shift_unit;

    localparam int WIDTH   = 32;
    localparam int SHAMT_W = 5;

    logic clk;
    logic reset;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    shift_unit_if #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) bus ();

    shift_unit #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one operation and measure Done latency, Busy cycles and the result.
    // With disturb set, Start/DataIn/ShiftAmt/Op are changed around edge 10.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [4:0] amt,
                          input logic [31:0] din, input logic [31:0] exp_data,
                          input int exp_lat, input int exp_busy, input bit disturb);
        int lat;
        int busy_cnt;
        lat      = 0;
        busy_cnt = 0;
        @(posedge clk); #1;
        bus.Start    = 1'b1;
        bus.Op       = op;
        bus.ShiftAmt = amt;
        bus.DataIn   = din;
        for (int k = 1; k <= 64; k++) begin
            @(posedge clk); #1;
            if (k == 1) bus.Start = 1'b0;
            if (disturb && k == 10) begin
                bus.Start    = 1'b1;
                bus.DataIn   = 32'hDEAD_BEEF;
                bus.ShiftAmt = 5'd3;
                bus.Op       = 2'b01;
            end
            if (disturb && k == 11) bus.Start = 1'b0;
            @(negedge clk);
            if (bus.Busy) busy_cnt++;
            if (bus.Done) begin
                lat = k;
                break;
            end
        end
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " busy cycles"}, busy_cnt, exp_busy);
        check({tag, " result"}, bus.DataOut, exp_data);
        // Done is a single-cycle pulse and the result holds in IDLE.
        @(negedge clk);
        check({tag, " done pulse width"}, {31'd0, bus.Done}, 32'd0);
        check({tag, " result hold"}, bus.DataOut, exp_data);
    endtask

    initial begin
        bit done_seen;
        int lat;

        reset        = 1'b1;
        bus.Start    = 1'b0;
        bus.Op       = 2'b00;
        bus.ShiftAmt = '0;
        bus.DataIn   = '0;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset DataOut", bus.DataOut, 32'h0);
        check("reset Busy", {31'd0, bus.Busy}, 32'd0);
        check("reset Done", {31'd0, bus.Done}, 32'd0);
        reset = 1'b0;

        // SLL by 16.
        run_op("sll16", 2'b00, 5'd16, 32'h0000_ABCD, 32'hABCD_0000, 17, 16, 1'b0);

        // SRA and SRL of the same operand.
        run_op("sra4", 2'b10, 5'd4, 32'h8000_00F0, 32'hF800_000F, 5, 4, 1'b0);
        run_op("srl4", 2'b01, 5'd4, 32'h8000_00F0, 32'h0800_000F, 5, 4, 1'b0);

        // Zero amount: straight to DONE, operand unchanged.
        run_op("zero", 2'b00, 5'd0, 32'h1234_5678, 32'h1234_5678, 1, 0, 1'b0);

        // Maximum amount with inputs disturbed mid-operation.
        run_op("sll31", 2'b00, 5'd31, 32'h0000_0001, 32'h8000_0000, 32, 31, 1'b1);

        // Maximum arithmetic shift fills every bit with the sign.
        run_op("sra31", 2'b10, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF, 32, 31, 1'b0);

        // Op=11.
`ifdef SHIFT_ROTATE_EN
        run_op("rot1", 2'b11, 5'd1, 32'h0000_0001, 32'h8000_0000, 2, 1, 1'b0);
        run_op("rot8", 2'b11, 5'd8, 32'h1234_5678, 32'h7812_3456, 9, 8, 1'b0);
`else
        run_op("pass", 2'b11, 5'd1, 32'h0000_0001, 32'h0000_0001, 1, 0, 1'b0);
        run_op("pass31", 2'b11, 5'd31, 32'hCAFE_F00D, 32'hCAFE_F00D, 1, 0, 1'b0);
`endif

        // Start in the DONE cycle is ignored.
        @(posedge clk); #1;
        bus.Start    = 1'b1;
        bus.Op       = 2'b00;
        bus.ShiftAmt = 5'd2;
        bus.DataIn   = 32'h0000_0003;
        lat = 0;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk); #1;
            if (k == 1) bus.Start = 1'b0;
            @(negedge clk);
            if (bus.Done) begin
                lat = k;
                break;
            end
        end
        check("done-start latency", lat, 3);
        bus.Start    = 1'b1;
        bus.ShiftAmt = 5'd0;
        bus.DataIn   = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        bus.Start = 1'b0;
        @(negedge clk);
        check("done-start ignored Done", {31'd0, bus.Done}, 32'd0);
        check("done-start ignored data", bus.DataOut, 32'h0000_000C);
        @(negedge clk);
        check("done-start still idle", {31'd0, bus.Done | bus.Busy}, 32'd0);

        // Reset abort in the middle of a long shift.
        @(posedge clk); #1;
        bus.Start    = 1'b1;
        bus.Op       = 2'b01;
        bus.ShiftAmt = 5'd20;
        bus.DataIn   = 32'hF0F0_F0F0;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            if (k == 1) bus.Start = 1'b0;
        end
        @(negedge clk);
        check("abort busy before reset", {31'd0, bus.Busy}, 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort DataOut", bus.DataOut, 32'h0);
        check("abort Busy", {31'd0, bus.Busy}, 32'd0);
        done_seen = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (bus.Done) done_seen = 1'b1;
            @(negedge clk);
        end
        check("abort no Done", {31'd0, done_seen}, 32'd0);

        // A fresh operation runs normally after the abort.
        run_op("after abort", 2'b00, 5'd1, 32'h4000_0001, 32'h8000_0002, 2, 1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
